spi_deserializer: RTL

Receive-side SPI stage that sits directly downstream of spi_serializer. It oversamples the serializer's sclk and mosi in the clk domain and rebuilds DATA_WIDTH-bit words, MSB first. Each completed word is pushed into the receive FIFO through a one-cycle write strobe. It also flags FIFO overflow and broken frames (sclk stalling mid-word).

---
 rtl/spi_defines_pkg.sv | 12 +
 rtl/spi_rx_sync.sv | 32 +++
 rtl/spi_deserializer.sv | 98 +++++++++
 3 files changed

// File: rtl/spi_defines_pkg.sv
// spi_defines_pkg: shared SPI word width plus receive-side FSM state and timeout sizing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
package spi_defines_pkg;
  localparam int RX_TIMEOUT_DEFAULT = 64;
  localparam int RX_TIMEOUT_W = $clog2(RX_TIMEOUT_DEFAULT);
  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE} rx_state_t;
  function automatic int rx_timeout_w(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/spi_rx_sync.sv
// spi_rx_sync: SYNC_STAGES-deep synchronizer for sclk/mosi with a registered sclk rising-edge strobe.
module spi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic mosi_o
);
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q;
  logic sclk_prev_q, rise_q, mosi_s_q;
  // mosi_s_q is delayed with rise_q so the strobe and its data bit stay aligned
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      rise_q      <= sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
      mosi_s_q    <= mosi_q[SYNC_STAGES-1];
    end
  end
  assign sclk_rise_o = rise_q;
  assign mosi_o      = mosi_s_q;
endmodule

// File: rtl/spi_deserializer.sv
// spi_deserializer: rebuilds MSB-first words from oversampled sclk/mosi and strobes them into the RX FIFO.
// Define SPI_RX_OVF_CNT_EN to add the 8-bit saturating dropped-word counter on ovf_count.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module spi_deserializer
  import spi_defines_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  full,
  input  logic                  clr_status,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [7:0]            ovf_count
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = rx_timeout_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  rx_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ovf_q, ovf_d;
  logic sclk_rise, mosi_s, word_done, drop;
  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk),
    .rst_ni      (rst),
    .sclk_i      (sclk),
    .mosi_i      (mosi),
    .sclk_rise_o (sclk_rise),
    .mosi_o      (mosi_s)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  // an edge landing in WRITE starts the next word rather than being lost
  always_comb begin
    word_done = state_q == RECEIVE && sclk_rise && cnt_q == LAST_BIT;
    state_d   = state_q == RECEIVE ? (word_done ? WRITE : frame_err ? IDLE : RECEIVE)
                                   : (sclk_rise ? RECEIVE : IDLE);
  end
  always_comb begin
    busy      = state_q != IDLE;
    write_en  = state_q == WRITE && !full;
    frame_err = state_q == RECEIVE && !sclk_rise && tmo_q == TMO_MAX;
    drop      = state_q == WRITE && full;
  end
  always_comb begin
    shift_d = sclk_rise ? {shift_q[DATA_WIDTH-2:0], mosi_s} : frame_err ? '0 : shift_q;
    cnt_d   = sclk_rise ? (state_q != RECEIVE ? CW'(1) : word_done ? '0 : cnt_q + CW'(1))
                        : frame_err ? '0 : cnt_q;
    tmo_d   = state_q != RECEIVE || sclk_rise || frame_err ? '0 : tmo_q + TW'(1);
    data_d  = word_done ? shift_d : data_q;
    ovf_d   = drop | (ovf_q & ~clr_status);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end
  assign write_data = data_q;
  assign overflow   = ovf_q;
`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  // a drop in the same cycle as clr_status restarts the count at one
  always_comb ovf_cnt_d = drop ? (clr_status ? 8'd1 : ovf_cnt_q + {7'd0, ~&ovf_cnt_q})
                               : clr_status ? '0 : ovf_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end
  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif
endmodule
